// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and the sequence-detector benches.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SEQ_W = 4;
    localparam logic [SEQ_W-1:0] SEQ_1010 = 4'b1010;

    // Counter width for a modulo-N timer; never narrower than one bit.
    function automatic int unsigned timer_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Modulo-BIT_CYCLES counter; o_bit_end_c strobes on the last cycle of each bit period.
module seq_bit_timer
    import seq_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_bit_end_c
);

    localparam int unsigned TW = timer_w(BIT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] r_cnt;
    logic          w_last;

    assign w_last      = (r_cnt == LAST);
    assign o_bit_end_c = i_en && w_last;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated back-to-back,
// holding each bit BIT_CYCLES clocks, then pulses o_done for one cycle.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned PATTERN_W  = SEQ_W,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [PATTERN_W-1:0] i_pattern,
    input  logic [CNT_W-1:0]     i_count,
    output logic                 o_bit,
    output logic                 o_bit_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned IW = $clog2(PATTERN_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(PATTERN_W - 1);

    state_t               r_state, w_state_n;
    logic [PATTERN_W-1:0] r_shift, w_shift_n;
    logic [PATTERN_W-1:0] r_pattern, w_pattern_n;
    logic [IW-1:0]        r_idx, w_idx_n;
    logic [CNT_W-1:0]     r_rep, w_rep_n;
    logic                 r_bit, w_bit_n;
    logic                 r_valid, w_valid_n;
    logic                 r_busy, w_busy_n;
    logic                 r_done, w_done_n;
    logic                 w_timer_en;
    logic                 w_timer_clr;
    logic                 w_bit_end;

    assign w_timer_en  = (r_state == SEND);
    assign w_timer_clr = (r_state != SEND);

    seq_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_en        (w_timer_en),
        .i_clr       (w_timer_clr),
        .o_bit_end_c (w_bit_end)
    );

    // r_shift holds the bits still to be sent after the one currently on o_bit.
    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_pattern_n = r_pattern;
        w_idx_n     = r_idx;
        w_rep_n     = r_rep;
        w_bit_n     = r_bit;
        w_valid_n   = r_valid;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_n   = SEND;
                    w_pattern_n = i_pattern;
                    w_shift_n   = {i_pattern[PATTERN_W-2:0], 1'b0};
                    w_rep_n     = (i_count == '0) ? CNT_W'(1) : i_count;
                    w_idx_n     = '0;
                    w_bit_n     = i_pattern[PATTERN_W-1];
                    w_valid_n   = 1'b1;
                    w_busy_n    = 1'b1;
                end
            end
            SEND: begin
                if (w_bit_end) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_n   = r_idx + IW'(1);
                        w_bit_n   = r_shift[PATTERN_W-1];
                        w_shift_n = {r_shift[PATTERN_W-2:0], 1'b0};
                    end else if (r_rep > CNT_W'(1)) begin
                        // Repeat from the captured copy so live input changes cannot leak in.
                        w_rep_n   = r_rep - CNT_W'(1);
                        w_idx_n   = '0;
                        w_bit_n   = r_pattern[PATTERN_W-1];
                        w_shift_n = {r_pattern[PATTERN_W-2:0], 1'b0};
                    end else begin
                        w_state_n = DONE;
                        w_idx_n   = '0;
                        w_rep_n   = '0;
                        w_shift_n = '0;
                        w_bit_n   = 1'b0;
                        w_valid_n = 1'b0;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
                w_bit_n   = 1'b0;
                w_valid_n = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_pattern <= '0;
            r_idx     <= '0;
            r_rep     <= '0;
            r_bit     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_pattern <= w_pattern_n;
            r_idx     <= w_idx_n;
            r_rep     <= w_rep_n;
            r_bit     <= w_bit_n;
            r_valid   <= w_valid_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
        end
    end

    assign o_bit       = r_bit;
    assign o_bit_valid = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
